load_align_unit: RTL and testbench

Load-side counterpart of the store byte-lane steering. Accepts one load from the execute stage and issues a word-aligned read to data memory. Waits for the variable-latency read response, then extracts the addressed byte, halfword or word, sign- or zero-extends it and presents it to writeback. Holds at most one load in flight and stalls the pipeline while busy.

---
 rtl/riscv_mem_pkg.sv | 35 +++
 rtl/load_extract.sv | 26 ++
 rtl/load_align_unit.sv | 115 +++++++++++
 tb/tb_load_align_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared load/store select encodings and load FSM state type
package riscv_mem_pkg;

    localparam int XLEN = 32;

    // Load select, funct3 encoding
    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    // Store select, funct3 encoding, shared with the store mux
    localparam logic [2:0] SEL_SB = 3'b000;
    localparam logic [2:0] SEL_SH = 3'b001;
    localparam logic [2:0] SEL_SW = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } ld_state_e;

    // Reserved selects behave as LW, so they share its alignment rule
    function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] off);
        case (sel)
            LD_B, LD_BU: is_misaligned = 1'b0;
            LD_H, LD_HU: is_misaligned = off[0];
            default:     is_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - selects the addressed byte/halfword/word and sign/zero-extends it
module load_extract
    import riscv_mem_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_sel,
    output logic [XLEN-1:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_off, 3'b000} +: 8];
        w_half = i_rdata[{i_off[1], 4'b0000} +: 16];
        case (i_sel)
            LD_B:    o_result = {{24{w_byte[7]}}, w_byte};
            LD_BU:   o_result = {24'd0, w_byte};
            LD_H:    o_result = {{16{w_half[15]}}, w_half};
            LD_HU:   o_result = {16'd0, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - single-outstanding load unit: word-aligned read, lane extract, writeback
module load_align_unit
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        LoadSel,
    input  logic [4:0]        ld_rd,
    input  logic              flush,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              ld_misaligned,
    output logic              stall
);

    ld_state_e         r_state;
    ld_state_e         w_next;
    logic [1:0]        r_off;
    logic [2:0]        r_sel;
    logic [4:0]        r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic              r_mis;
    logic [DATA_W-1:0] r_wb_data;
    logic [4:0]        r_wb_rd;
    logic              w_accept;
    logic              w_mis;
    logic              w_capture;
    logic [DATA_W-1:0] w_result;

    assign w_accept  = (r_state == S_IDLE) && ld_valid && !flush;
    assign w_mis     = is_misaligned(LoadSel, ld_addr[1:0]);
    assign w_capture = (r_state == S_WAIT) && dmem_rvalid && !flush;

    load_extract u_extract (
        .i_rdata  (dmem_rdata),
        .i_off    (r_off),
        .i_sel    (r_sel),
        .o_result (w_result)
    );

    always_comb begin
        w_next         = r_state;
        dmem_req_valid = 1'b0;
        wb_valid       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_mis) w_next = S_REQ;
            end
            S_REQ: begin
                dmem_req_valid = !flush;
                if (flush)               w_next = S_IDLE;
                else if (dmem_req_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                // A response coinciding with the flush has nothing left to drain
                if (dmem_rvalid)         w_next = flush ? S_IDLE : S_RESP;
                else if (flush)          w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (dmem_rvalid) w_next = S_IDLE;
            end
            S_RESP: begin
                wb_valid = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_off     <= 2'd0;
            r_sel     <= 3'd0;
            r_rd      <= 5'd0;
            r_addr    <= '0;
            r_mis     <= 1'b0;
            r_wb_data <= '0;
            r_wb_rd   <= 5'd0;
        end else begin
            r_state <= w_next;
            r_mis   <= w_accept && w_mis;
            if (w_accept) begin
                r_off  <= ld_addr[1:0];
                r_sel  <= LoadSel;
                r_rd   <= ld_rd;
                r_addr <= {ld_addr[ADDR_W-1:2], 2'b00};
            end
            if (w_capture) begin
                r_wb_data <= w_result;
                r_wb_rd   <= r_rd;
            end
        end
    end

    assign ld_ready      = (r_state == S_IDLE);
    assign stall         = (r_state != S_IDLE);
    assign dmem_addr     = r_addr;
    assign ld_misaligned = r_mis;
    assign wb_data       = r_wb_data;
    assign wb_rd         = r_wb_rd;

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - vector table plus scoreboard bench for load_align_unit
module tb_load_align_unit;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [2:0]  LoadSel;
    logic [4:0]  ld_rd;
    logic        flush;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ld_misaligned;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;
    int n_wb     = 0;
    int n_exp_wb = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          cyc;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  sel;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[11];

    load_align_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .LoadSel        (LoadSel),
        .ld_rd          (ld_rd),
        .flush          (flush),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_addr      (dmem_addr),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .ld_misaligned  (ld_misaligned),
        .stall          (stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (wb_valid) begin
            n_wb++;
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("wb_data", wb_data, e.data);
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_latency", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [31:0] addr, input logic [2:0] sel, input logic [4:0] rd,
                            input logic [31:0] rdata, input int req_wait, input int rsp_wait,
                            input logic [31:0] exp);
        logic [31:0] waddr;
        waddr    = {addr[31:2], 2'b00};
        ld_valid = 1'b1;
        ld_addr  = addr;
        LoadSel  = sel;
        ld_rd    = rd;
        @(negedge clk);
        chk("accept_ready", ld_ready, 1'b1);
        sb_q.push_back('{exp, rd, cyc + 3 + req_wait + rsp_wait});
        n_exp_wb++;
        step();
        ld_valid = 1'b0;
        ld_addr  = $urandom;
        ld_rd    = 5'($urandom);
        for (int i = 0; i < req_wait; i++) begin
            @(negedge clk);
            chk("bp_req_valid", dmem_req_valid, 1'b1);
            chk("bp_addr", dmem_addr, waddr);
            chk("bp_ready_low", ld_ready, 1'b0);
            step();
        end
        dmem_req_ready = 1'b1;
        @(negedge clk);
        chk("req_valid", dmem_req_valid, 1'b1);
        chk("dmem_addr", dmem_addr, waddr);
        step();
        dmem_req_ready = 1'b0;
        for (int i = 0; i < rsp_wait; i++) begin
            @(negedge clk);
            chk("wait_stall", stall, 1'b1);
            chk("wait_no_req", dmem_req_valid, 1'b0);
            step();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        @(negedge clk);
        chk("wait_stall", stall, 1'b1);
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
        @(negedge clk);
        chk("resp_stall", stall, 1'b1);
        chk("resp_ready", ld_ready, 1'b0);
        step();
        @(negedge clk);
        chk("post_wb_valid", wb_valid, 1'b0);
        chk("post_stall", stall, 1'b0);
        step();
    endtask

    task automatic run_misaligned(input logic [31:0] addr, input logic [2:0] sel);
        ld_valid = 1'b1;
        ld_addr  = addr;
        LoadSel  = sel;
        ld_rd    = 5'd3;
        @(negedge clk);
        chk("mis_pre", ld_misaligned, 1'b0);
        step();
        ld_valid = 1'b0;
        @(negedge clk);
        chk("mis_pulse", ld_misaligned, 1'b1);
        chk("mis_no_req", dmem_req_valid, 1'b0);
        chk("mis_idle", ld_ready, 1'b1);
        chk("mis_stall", stall, 1'b0);
        step();
        @(negedge clk);
        chk("mis_end", ld_misaligned, 1'b0);
        chk("mis_no_req2", dmem_req_valid, 1'b0);
        step();
    endtask

    initial begin
        vecs[0]  = '{32'h0000_1001, LD_B,   5'd1,  32'h8899_AABB, 32'hFFFF_FFAA};
        vecs[1]  = '{32'h0000_1003, LD_BU,  5'd2,  32'h8899_AABB, 32'h0000_0088};
        vecs[2]  = '{32'h0000_1002, LD_H,   5'd3,  32'h8899_AABB, 32'hFFFF_8899};
        vecs[3]  = '{32'h0000_1000, LD_HU,  5'd4,  32'h8899_AABB, 32'h0000_AABB};
        vecs[4]  = '{32'h0000_1000, LD_W,   5'd5,  32'h8899_AABB, 32'h8899_AABB};
        vecs[5]  = '{32'h0000_1001, LD_BU,  5'd6,  32'h8899_AABB, 32'h0000_00AA};
        vecs[6]  = '{32'h0000_1003, LD_B,   5'd8,  32'h8899_AABB, 32'hFFFF_FF88};
        vecs[7]  = '{32'h0000_2000, LD_B,   5'd9,  32'h0000_007F, 32'h0000_007F};
        vecs[8]  = '{32'h0000_2002, LD_HU,  5'd10, 32'hF00D_1234, 32'h0000_F00D};
        vecs[9]  = '{32'h0000_2000, LD_H,   5'd31, 32'hF00D_1234, 32'h0000_1234};
        vecs[10] = '{32'h0000_3000, 3'b011, 5'd12, 32'hCAFE_BABE, 32'hCAFE_BABE};

        rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; LoadSel = '0; ld_rd = '0;
        flush = 1'b0; dmem_req_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        @(negedge clk);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_req_valid", dmem_req_valid, 1'b0);
        chk("rst_ready", ld_ready, 1'b1);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++)
            run_load(vecs[i].addr, vecs[i].sel, vecs[i].rd, vecs[i].rdata, 0, 0, vecs[i].exp);

        // Backpressure: 3 cycles of req_ready low, response 2 cycles after handshake
        run_load(32'h0000_1002, LD_HU, 5'd7, 32'h8899_AABB, 3, 2, 32'h0000_8899);

        begin
            int wb_before;
            wb_before = n_wb;
            run_misaligned(32'h0000_1002, LD_W);
            run_misaligned(32'h0000_1003, LD_H);
            run_misaligned(32'h0000_1001, LD_HU);
            chk("mis_no_wb", n_wb, wb_before);
        end

        // Flush in WAIT: response arrives later and must be dropped
        ld_valid = 1'b1; ld_addr = 32'h0000_6000; LoadSel = LD_W; ld_rd = 5'd14;
        step();
        ld_valid = 1'b0; dmem_req_ready = 1'b1;
        @(negedge clk);
        chk("fw_req_valid", dmem_req_valid, 1'b1);
        step();
        dmem_req_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("fw_stall", stall, 1'b1);
        step();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("fw_drain_stall", stall, 1'b1);
            chk("fw_drain_ready", ld_ready, 1'b0);
            step();
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("fw_drain_last", stall, 1'b1);
        step();
        dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("fw_no_wb", wb_valid, 1'b0);
        chk("fw_idle", ld_ready, 1'b1);
        step();
        run_load(32'h0000_6000, LD_W, 5'd15, 32'hA5A5_0F0F, 0, 0, 32'hA5A5_0F0F);

        // Flush in REQ coincident with req_ready
        ld_valid = 1'b1; ld_addr = 32'h0000_5000; LoadSel = LD_W; ld_rd = 5'd16;
        step();
        ld_valid = 1'b0; flush = 1'b1; dmem_req_ready = 1'b1;
        @(negedge clk);
        chk("fr_req_valid", dmem_req_valid, 1'b0);
        step();
        flush = 1'b0; dmem_req_ready = 1'b0;
        @(negedge clk);
        chk("fr_idle", ld_ready, 1'b1);
        chk("fr_stall", stall, 1'b0);
        chk("fr_no_req", dmem_req_valid, 1'b0);
        step();

        // Reset mid-WAIT followed by a stray response
        ld_valid = 1'b1; ld_addr = 32'h0000_4000; LoadSel = LD_W; ld_rd = 5'd9;
        step();
        ld_valid = 1'b0; dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        @(negedge clk);
        chk("rw_wait_stall", stall, 1'b1);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rw_stall", stall, 1'b0);
        chk("rw_ready", ld_ready, 1'b1);
        chk("rw_wb_data", wb_data, 32'h0);
        chk("rw_wb_rd", {27'd0, wb_rd}, 32'h0);
        chk("rw_dmem_addr", dmem_addr, 32'h0);
        chk("rw_req_valid", dmem_req_valid, 1'b0);
        step();
        rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rw_stray", wb_valid, 1'b0);
        step();
        dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("rw_stray2", wb_valid, 1'b0);
        chk("rw_ready2", ld_ready, 1'b1);
        chk("rw_wb_data2", wb_data, 32'h0);
        step();

        repeat (3) step();
        chk("sb_empty", sb_q.size(), 32'd0);
        chk("wb_count", n_wb, n_exp_wb);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
